// File: rtl/instr_fetch_buffer_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/gnt/rvalid
// channel and the valid/ready channel towards decode.
interface instr_fetch_buffer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: credit-limited word fetches, in-order response FIFO
// tagged with PCs, and redirect flush with drop counting of stale responses.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_fetch_buffer_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]    state, state_next;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight, drop, count;
    logic [CW-1:0] inflight_next, drop_next, count_next;
    logic [AW-1:0] wr_ptr, rd_ptr, pcq_wr, pcq_rd;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   pcq        [DEPTH];
    logic          grant, accept, rsp_take, rsp_drop, push, pop, credit;
    logic          unused_ok;

    assign unused_ok = ^bus.redirect_pc[1:0];

    // Handshake qualification; a grant seen while redirecting still owes a response
    always_comb begin
        grant    = (state == REQ) && bus.imem_gnt;
        accept   = grant && !bus.redirect_valid;
        rsp_drop = bus.imem_rvalid && (drop != '0);
        rsp_take = bus.imem_rvalid && (drop == '0) && (inflight != '0);
        push     = rsp_take && !bus.redirect_valid;
        pop      = bus.if_valid && bus.if_ready;
    end

    // Next counter values; pending drops hold credit so drop can never exceed DEPTH
    always_comb begin
        inflight_next = inflight - CW'(rsp_take) + CW'(accept);
        count_next    = count + CW'(push) - CW'(pop);
        drop_next     = drop - CW'(rsp_drop);
        if (bus.redirect_valid) begin
            drop_next     = drop - CW'(rsp_drop) + inflight - CW'(rsp_take) + CW'(grant);
            inflight_next = '0;
            count_next    = '0;
        end
        credit = (SW'(count_next) + SW'(inflight_next) + SW'(drop_next)) < SW'(DEPTH);
    end

    always_comb begin
        state_next = state;
        if (bus.redirect_valid) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (credit) state_next = REQ;
                REQ:     if (accept && !credit) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Fetch PC, PC tag queue for in-flight requests, and the response FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
                pcq[i]        <= '0;
            end
        end else begin
            inflight <= inflight_next;
            drop     <= drop_next;
            count    <= count_next;
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                pcq_wr   <= '0;
                pcq_rd   <= '0;
            end else begin
                if (accept) begin
                    pcq[pcq_wr] <= fetch_pc;
                    pcq_wr      <= pcq_wr + AW'(1);
                    fetch_pc    <= fetch_pc + 32'd4;
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    fifo_pc[wr_ptr]    <= pcq[pcq_rd];
                    wr_ptr             <= wr_ptr + AW'(1);
                    pcq_rd             <= pcq_rd + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign bus.imem_req  = (state == REQ) && !bus.redirect_valid;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = (count != '0) && !bus.redirect_valid;
    assign bus.if_instr  = fifo_instr[rd_ptr];
    assign bus.if_pc     = fifo_pc[rd_ptr];
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: a memory model answers grants,
// expected PCs are queued by the directed tests and checked on each pop.
module tb_instr_fetch_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_buffer_if bus();

    instr_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc_q[$];
    rsp_t        rsp_q[$];
    int          lat       = 1;
    bit          dead_mode = 1'b0;
    int          cyc       = 0;
    bit          prev_req  = 1'b0;
    bit          prev_gnt  = 1'b0;
    int          first_req, first_val;
    bit          found;
    logic [31:0] found_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: responds in order, lat cycles after each grant
    always @(posedge clk) begin : mem_model
        bit          granted;
        logic [31:0] a;
        rsp_t        r;
        granted  = bus.imem_gnt && (bus.imem_req || (bus.redirect_valid && prev_req && !prev_gnt));
        a        = bus.imem_addr;
        prev_req = bus.imem_req;
        prev_gnt = bus.imem_gnt;
        if (!rst_n) begin
            rsp_q.delete();
            granted  = 1'b0;
            prev_req = 1'b0;
        end
        if (granted) begin
            r.due  = cyc + lat;
            r.data = dead_mode ? 32'h0000_DEAD : instr_of(a);
            rsp_q.push_back(r);
        end
        cyc++;
        #1;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
    end

    // Pops every accepted head against the expected-PC queue
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.if_valid && bus.if_ready) begin
                if (exp_pc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got pc 0x%08h, no entry expected", bus.if_pc);
                end else begin
                    e = exp_pc_q.pop_front();
                    check("pop_pc", bus.if_pc, e);
                    check("pop_instr", bus.if_instr, instr_of(e));
                end
            end
        end
    endtask

    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
            else step();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_pc_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        bus.if_ready = 1'b0;
        check(name, 32'(exp_pc_q.size()), 32'd0);
        exp_pc_q.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
    endtask

    task automatic find_req(input int budget);
        found      = 1'b0;
        found_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                found      = 1'b1;
                found_addr = bus.imem_addr;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_gnt       = 1'b0;
        bus.if_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_imem_req", 32'(bus.imem_req), 32'd0);
        check("reset_if_valid", 32'(bus.if_valid), 32'd0);
        check("reset_if_instr", bus.if_instr, 32'h0);
        check("reset_if_pc", bus.if_pc, 32'h0);
        check("reset_imem_addr", bus.imem_addr, 32'h0);

        // Streaming fetch with immediate grants and responses
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        exp_pc_q = '{32'h0, 32'h4, 32'h8};
        @(posedge clk);
        #1 rst_n = 1'b1;
        first_req = -1;
        first_val = -1;
        for (int c = 0; c < 40 && exp_pc_q.size() != 0; c++) begin
            @(negedge clk);
            if (first_req < 0 && bus.imem_req) begin
                first_req = c;
                check("t1_first_addr", bus.imem_addr, 32'h0);
            end
            if (first_val < 0 && bus.if_valid) first_val = c;
            step();
        end
        bus.if_ready = 1'b0;
        check("t1_drained", 32'(exp_pc_q.size()), 32'd0);
        check("t1_latency", 32'(first_val - first_req), 32'd2);

        // Decode stalled: buffer fills and requests stop at the next address
        redirect_to(32'h0);
        @(negedge clk);
        check("t2_redirect_req", 32'(bus.imem_req), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        repeat (15) step();
        @(negedge clk);
        check("t2_full_valid", 32'(bus.if_valid), 32'd1);
        check("t2_head_pc", bus.if_pc, 32'h0);
        check("t2_req_dropped", 32'(bus.imem_req), 32'd0);
        check("t2_hold_addr", bus.imem_addr, 32'h8);
        exp_pc_q = '{32'h0, 32'h4, 32'h8};
        step();
        bus.if_ready = 1'b1;
        find_req(10);
        check("t2_resume_addr", found_addr, 32'h8);
        drain("t2_drained");

        // Withheld grant: request and address must stay stable
        bus.imem_gnt = 1'b0;
        redirect_to(32'h0);
        step();
        bus.redirect_valid = 1'b0;
        wait_req("t3_wait_req");
        check("t3_hold_req_0", 32'(bus.imem_req), 32'd1);
        check("t3_hold_addr_0", bus.imem_addr, 32'h0);
        for (int i = 1; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t3_hold_req", 32'(bus.imem_req), 32'd1);
            check("t3_hold_addr", bus.imem_addr, 32'h0);
        end
        exp_pc_q = '{32'h0, 32'h4};
        step();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        drain("t3_drained");

        // Two requests in flight when redirected: both responses discarded
        bus.imem_gnt = 1'b0;
        lat          = 3;
        dead_mode    = 1'b1;
        redirect_to(32'h200);
        step();
        bus.redirect_valid = 1'b0;
        wait_req("t4_wait_req");
        check("t4_first_addr", bus.imem_addr, 32'h200);
        step();
        bus.imem_gnt = 1'b1;
        step();
        @(negedge clk);
        check("t4_second_req", 32'(bus.imem_req), 32'd1);
        check("t4_second_addr", bus.imem_addr, 32'h204);
        redirect_to(32'h100);
        dead_mode = 1'b0;
        @(negedge clk);
        check("t4_redirect_valid", 32'(bus.if_valid), 32'd0);
        check("t4_redirect_req", 32'(bus.imem_req), 32'd0);
        exp_pc_q = '{32'h100, 32'h104};
        step();
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b1;
        drain("t4_drained");

        // Unaligned redirect target with a grant in the redirect cycle
        lat          = 1;
        bus.imem_gnt = 1'b0;
        redirect_to(32'h300);
        step();
        bus.redirect_valid = 1'b0;
        wait_req("t5_wait_req");
        redirect_to(32'h102);
        bus.imem_gnt = 1'b1;
        dead_mode    = 1'b1;
        @(negedge clk);
        check("t5_redirect_req", 32'(bus.imem_req), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_gnt       = 1'b0;
        dead_mode          = 1'b0;
        @(negedge clk);
        check("t5_aligned_addr", bus.imem_addr, 32'h100);
        exp_pc_q = '{32'h100, 32'h104};
        step();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        drain("t5_drained");

        // Reset in the middle of traffic with a full buffer
        repeat (12) step();
        @(negedge clk);
        check("t6_prefill_valid", 32'(bus.if_valid), 32'd1);
        redirect_to(32'h400);
        @(negedge clk);
        check("t6_redirect_hides_valid", 32'(bus.if_valid), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        repeat (12) step();
        @(negedge clk);
        check("t6_full_valid", 32'(bus.if_valid), 32'd1);
        check("t6_full_head", bus.if_pc, 32'h400);
        check("t6_full_req", 32'(bus.imem_req), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.if_valid), 32'd0);
        check("t6_rst_req", 32'(bus.imem_req), 32'd0);
        check("t6_rst_addr", bus.imem_addr, 32'h0);
        check("t6_rst_pc", bus.if_pc, 32'h0);
        exp_pc_q = '{32'h0, 32'h4};
        bus.if_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        find_req(10);
        check("t6_restart_addr", found_addr, 32'h0);
        drain("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
